key_command_decoder: RTL and testbench
======================================

# key_command_decoder

Turns the byte stream from the UART keyboard receiver into game commands for the Player and Machine blocks. The keyboard link only reports key presses, with no releases. In the bullet (dodge) phase, the block holds each direction for a fixed number of movement ticks and emits step pulses. In the menu phase, it drives a wrapping action cursor and issues confirmed commands over a valid/ready handshake. It sits between the UART receiver and the `playerInstruction` consumers.

## Interface
- `HOLD_TICKS`, 3: ticks a direction stays held after its last key press (1..15).
- `MENU_ITEMS`, 4: number of menu actions (2..4).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte, qualified by `rx_valid`.
- `rx_valid` in 1: one-cycle strobe, new byte present.
- `tick` in 1: one-cycle movement enable (10 Hz rate, single `clk` wide).
- `dodge_phase` in 1: 1 = bullet phase, 0 = menu phase.
- `cmd_ready` in 1: consumer accepts the command this cycle.
- `step` out 4: one-cycle step pulses {up, down, left, right}.
- `dir_held` out 4: directions currently held {up, down, left, right}.
- `cursor` out 2: selected menu action, 0..MENU_ITEMS-1.
- `cmd_valid` out 1: command pending.
- `cmd_code` out 2: action being issued; stable while `cmd_valid` is high.
- `bad_key` out 1: one-cycle pulse when an unrecognised byte arrives in MENU or DODGE.
- `player_instruction` out 16: {`dir_held`[15:12], `cursor`[11:10], `cmd_code`[9:8], `cmd_valid`[7], `dodge_phase`[6], 6'b0}.

## Operation
- Key map (upper and lower case are equivalent):
  - w/W = up, s/S = down, a/A = left, d/D = right.
  - j/J or 0x0D = confirm.
  - Any other byte sets `bad_key`.
- State machine:
  - States are MENU, DODGE and WAIT_ACK; reset enters MENU.
  - MENU → DODGE when `dodge_phase`=1. DODGE → MENU when `dodge_phase`=0.
  - MENU → WAIT_ACK on confirm.
  - WAIT_ACK → DODGE or MENU (chosen by `dodge_phase`) on the cycle after `cmd_valid`&&`cmd_ready`.
- MENU:
  - Left decrements `cursor`; 0 wraps to MENU_ITEMS-1.
  - Right increments `cursor`; MENU_ITEMS-1 wraps to 0.
  - Up, down and confirm-free keys do not change `cursor`; up and down are silently ignored, with no `bad_key`.
  - Confirm sets `cmd_valid`=1 and `cmd_code`=`cursor`.
- WAIT_ACK:
  - `cmd_valid` stays high and `cmd_code` stays frozen until `cmd_ready` is sampled high.
  - `cmd_valid` clears in the cycle after the handshake.
  - All bytes are dropped, with no `bad_key`.
  - A change of `dodge_phase` takes effect only after the acknowledge.
- DODGE:
  - Each direction has its own 4-bit hold counter; `dir_held[i]` = (counter[i]≠0).
  - A direction key loads that counter with HOLD_TICKS and zeroes the opposite one (up/down, left/right).
  - On `tick`, every nonzero counter pulses its `step` bit and decrements.
  - Confirm is ignored in DODGE.
- Leaving DODGE clears all counters, `dir_held` and `step` in the same transition.
- `cursor` is retained across phases.

## Timing
- Reset values:
  - All outputs are 0, all counters are 0, state is MENU.
  - `player_instruction` reflects `dodge_phase` only.
- `step` is registered: it is high in the cycle after `tick`, for exactly one cycle.
- `dir_held`, `cursor` and `cmd_valid` update in the cycle after `rx_valid`.
- A key press followed by `tick` gives the first `step` one cycle after that tick.
  - A held direction produces exactly HOLD_TICKS steps if no further key arrives.
- `rx_valid` and `tick` in the same cycle:
  - The tick acts on the pre-key counters: it pulses and decrements.
  - The key load then wins: the pressed counter ends at HOLD_TICKS.
  - The opposite counter is zeroed, but its `step` still fires from the pre-key value.
- `cmd_valid` may rise with `cmd_ready` already high: the handshake completes that cycle, and `cmd_valid` is high for 1 cycle.
- Reset asserted mid-hold or mid-handshake aborts the operation with no `step` or `cmd_valid` afterwards.
- No combinational path from any input to any output.

## Test plan
- Reset, then `dodge_phase`=1, send 'w', 4 ticks → `step`[3] pulses exactly 3 times; `dir_held`=4'b0000 after the 3rd tick.
- DODGE: send 'w', then 's' before a tick → `dir_held`=4'b0100. Send 'A' and 'd' in the same tick window → only right held. Byte 0x31 → `bad_key` one cycle.
- MENU, `cursor`=0: 'a' → 3; 'd','d' → 1; with MENU_ITEMS=3, 'a' from 0 → 2.
- MENU `cursor`=2, send 0x0D with `cmd_ready`=0 for 5 cycles → `cmd_valid` high and `cmd_code`=2 throughout. A 'd' during the wait leaves `cursor`=2. Raise `cmd_ready` → `cmd_valid`=0 the next cycle, state MENU.
- `rx_valid`('d') and `tick` coincident with the right counter at 1 → `step`[0] pulses and the counter ends at HOLD_TICKS.
- Holding left with `dodge_phase` dropping to 0 → `dir_held`=0 next cycle; a later `tick` gives no `step`. Reset during WAIT_ACK → `cmd_valid`=0, state MENU.

Source files
------------

// File: rtl/key_command_decoder.sv
// Keyboard byte decoder: turns UART key presses into held-direction step pulses
// in the bullet phase and a wrapping menu cursor with a valid/ready command in the menu phase.
module key_command_decoder #(
   parameter int HOLD_TICKS = 3,
   parameter int MENU_ITEMS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        tick,
   input  logic        dodge_phase,
   input  logic        cmd_ready,
   output logic [3:0]  step,
   output logic [3:0]  dir_held,
   output logic [1:0]  cursor,
   output logic        cmd_valid,
   output logic [1:0]  cmd_code,
   output logic        bad_key,
   output logic [15:0] player_instruction
);

   typedef enum logic [1:0] {MENU, DODGE, WAIT_ACK} state_t;

   localparam logic [3:0] HOLD = 4'(HOLD_TICKS);
   localparam logic [1:0] LAST = 2'(MENU_ITEMS - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q [4];
   logic [3:0] cnt_d [4];
   logic [3:0] step_q, step_d;
   logic [1:0] cursor_q, cursor_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic [1:0] cmd_code_q, cmd_code_d;
   logic       bad_key_q, bad_key_d;
   logic       dodge_phase_q;

   logic [3:0] key_dir;
   logic       key_confirm;
   logic       key_other;

   always_comb begin
      key_dir     = 4'b0000;
      key_confirm = 1'b0;
      key_other   = 1'b0;
      case (rx_data)
         8'h77, 8'h57: key_dir = 4'b1000;
         8'h73, 8'h53: key_dir = 4'b0100;
         8'h61, 8'h41: key_dir = 4'b0010;
         8'h64, 8'h44: key_dir = 4'b0001;
         8'h6A, 8'h4A, 8'h0D: key_confirm = 1'b1;
         default: key_other = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = 4'b0000;
      cursor_d    = cursor_q;
      cmd_valid_d = cmd_valid_q;
      cmd_code_d  = cmd_code_q;
      bad_key_d   = 1'b0;
      case (state_q)
         MENU: begin
            if (rx_valid) begin
               if (key_dir[1])
                  cursor_d = (cursor_q == 2'd0) ? LAST : cursor_q - 2'd1;
               else if (key_dir[0])
                  cursor_d = (cursor_q == LAST) ? 2'd0 : cursor_q + 2'd1;
               bad_key_d = key_other;
            end
            // A confirm wins over a simultaneous phase change
            if (rx_valid && key_confirm) begin
               cmd_valid_d = 1'b1;
               cmd_code_d  = cursor_q;
               state_d     = WAIT_ACK;
            end else if (dodge_phase) begin
               state_d = DODGE;
            end
         end
         DODGE: begin
            bad_key_d = rx_valid && key_other;
            if (!dodge_phase) begin
               state_d = MENU;
               for (int i = 0; i < 4; i++) cnt_d[i] = 4'd0;
            end else begin
               // Tick acts on the pre-key counters, then the key load overrides
               if (tick) begin
                  for (int i = 0; i < 4; i++) begin
                     if (cnt_q[i] != 4'd0) begin
                        step_d[i] = 1'b1;
                        cnt_d[i]  = cnt_q[i] - 4'd1;
                     end
                  end
               end
               if (rx_valid) begin
                  for (int i = 0; i < 4; i++) begin
                     if (key_dir[i]) begin
                        cnt_d[i]     = HOLD;
                        cnt_d[i ^ 1] = 4'd0;
                     end
                  end
               end
            end
         end
         WAIT_ACK: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = dodge_phase ? DODGE : MENU;
            end
         end
         default: state_d = MENU;
      endcase
   end

   always_ff @(posedge clk) begin
      dodge_phase_q <= dodge_phase;
      if (reset) begin
         state_q     <= MENU;
         cnt_q       <= '{default: 4'd0};
         step_q      <= 4'b0000;
         cursor_q    <= 2'd0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 2'd0;
         bad_key_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         cursor_q    <= cursor_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         bad_key_q   <= bad_key_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) dir_held[i] = (cnt_q[i] != 4'd0);
   end

   assign step               = step_q;
   assign cursor             = cursor_q;
   assign cmd_valid          = cmd_valid_q;
   assign cmd_code           = cmd_code_q;
   assign bad_key            = bad_key_q;
   assign player_instruction = {dir_held, cursor_q, cmd_code_q, cmd_valid_q, dodge_phase_q, 6'b0};

endmodule

// File: tb/tb_key_command_decoder.sv
// Directed bench for key_command_decoder: a vector table for the main flow plus
// hand-written sequences for handshake, phase-change and reset corner cases.
module tb_key_command_decoder;

   localparam logic [7:0] K_W  = 8'h77;
   localparam logic [7:0] K_S  = 8'h73;
   localparam logic [7:0] K_A  = 8'h61;
   localparam logic [7:0] K_AU = 8'h41;
   localparam logic [7:0] K_D  = 8'h64;
   localparam logic [7:0] K_J  = 8'h6A;
   localparam logic [7:0] K_CR = 8'h0D;
   localparam logic [7:0] K_1  = 8'h31;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tick;
   logic        dodge_phase;
   logic        cmd_ready;
   logic [3:0]  step, dir_held;
   logic [1:0]  cursor, cmd_code;
   logic        cmd_valid, bad_key;
   logic [15:0] player_instruction;

   logic [3:0]  step3, dir_held3;
   logic [1:0]  cursor3, cmd_code3;
   logic        cmd_valid3, bad_key3;
   logic [15:0] player_instruction3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rv;
      logic [7:0] data;
      logic       tk;
      logic       dp;
      logic       rdy;
      logic [3:0] step;
      logic [3:0] held;
      logic [1:0] cur;
      logic       cv;
      logic [1:0] code;
      logic       bad;
   } vec_t;

   vec_t vecs[$];

   key_command_decoder #(.HOLD_TICKS(3), .MENU_ITEMS(4)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tick(tick),
      .dodge_phase(dodge_phase), .cmd_ready(cmd_ready), .step(step), .dir_held(dir_held),
      .cursor(cursor), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .bad_key(bad_key),
      .player_instruction(player_instruction)
   );

   key_command_decoder #(.HOLD_TICKS(3), .MENU_ITEMS(3)) dut3 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tick(tick),
      .dodge_phase(dodge_phase), .cmd_ready(cmd_ready), .step(step3), .dir_held(dir_held3),
      .cursor(cursor3), .cmd_valid(cmd_valid3), .cmd_code(cmd_code3), .bad_key(bad_key3),
      .player_instruction(player_instruction3)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkField(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge
   task automatic applyStimulus(input logic rv, input logic [7:0] data, input logic tk,
                                input logic dp, input logic rdy);
      rx_valid    = rv;
      rx_data     = data;
      tick        = tk;
      dodge_phase = dp;
      cmd_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] e_step, input logic [3:0] e_held,
                              input logic [1:0] e_cur, input logic e_cv, input logic [1:0] e_code,
                              input logic e_bad);
      logic [15:0] e_pi;
      e_pi = {e_held, e_cur, e_code, e_cv, dodge_phase, 6'b0};
      checkField({name, ".step"}, int'(step), int'(e_step));
      checkField({name, ".dir_held"}, int'(dir_held), int'(e_held));
      checkField({name, ".cursor"}, int'(cursor), int'(e_cur));
      checkField({name, ".cmd_valid"}, int'(cmd_valid), int'(e_cv));
      checkField({name, ".cmd_code"}, int'(cmd_code), int'(e_code));
      checkField({name, ".bad_key"}, int'(bad_key), int'(e_bad));
      checkField({name, ".player_instruction"}, int'(player_instruction), int'(e_pi));
   endtask

   task automatic addVec(input logic rv, input logic [7:0] data, input logic tk, input logic dp,
                         input logic rdy, input logic [3:0] st, input logic [3:0] held,
                         input logic [1:0] cur, input logic cv, input logic [1:0] code,
                         input logic bad);
      vec_t v;
      v.rv = rv; v.data = data; v.tk = tk; v.dp = dp; v.rdy = rdy;
      v.step = st; v.held = held; v.cur = cur; v.cv = cv; v.code = code; v.bad = bad;
      vecs.push_back(v);
   endtask

   initial begin
      // Main flow starting from MENU with cursor 0; columns: rv data tick dp rdy | step held cur cv code bad
      addVec(1, K_D,  0, 0, 0,  4'h0, 4'h0, 2'd1, 0, 2'd0, 0);
      addVec(1, K_D,  0, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd0, 0);
      addVec(1, K_W,  0, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd0, 0);
      addVec(1, K_1,  0, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd0, 1);
      addVec(0, 8'h0, 0, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd0, 0);
      addVec(1, K_CR, 0, 0, 0,  4'h0, 4'h0, 2'd2, 1, 2'd2, 0);
      addVec(0, 8'h0, 0, 0, 0,  4'h0, 4'h0, 2'd2, 1, 2'd2, 0);
      addVec(0, 8'h0, 0, 0, 0,  4'h0, 4'h0, 2'd2, 1, 2'd2, 0);
      addVec(0, 8'h0, 0, 0, 0,  4'h0, 4'h0, 2'd2, 1, 2'd2, 0);
      addVec(1, K_D,  0, 0, 0,  4'h0, 4'h0, 2'd2, 1, 2'd2, 0);
      addVec(0, 8'h0, 0, 0, 0,  4'h0, 4'h0, 2'd2, 1, 2'd2, 0);
      addVec(0, 8'h0, 0, 0, 1,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(1, K_A,  0, 0, 0,  4'h0, 4'h0, 2'd1, 0, 2'd2, 0);
      addVec(1, K_D,  0, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 0, 1, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(1, K_W,  0, 1, 0,  4'h0, 4'h8, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h8, 4'h8, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 0, 1, 0,  4'h0, 4'h8, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h8, 4'h8, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 0, 1, 0,  4'h0, 4'h8, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h8, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 0, 1, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 0, 1, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(1, K_W,  0, 1, 0,  4'h0, 4'h8, 2'd2, 0, 2'd2, 0);
      addVec(1, K_S,  0, 1, 0,  4'h0, 4'h4, 2'd2, 0, 2'd2, 0);
      addVec(1, K_AU, 0, 1, 0,  4'h0, 4'h6, 2'd2, 0, 2'd2, 0);
      addVec(1, K_D,  0, 1, 0,  4'h0, 4'h5, 2'd2, 0, 2'd2, 0);
      addVec(1, K_1,  0, 1, 0,  4'h0, 4'h5, 2'd2, 0, 2'd2, 1);
      addVec(1, K_J,  0, 1, 0,  4'h0, 4'h5, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h5, 4'h5, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h5, 4'h5, 2'd2, 0, 2'd2, 0);
      addVec(1, K_D,  1, 1, 0,  4'h5, 4'h1, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 0, 1, 0,  4'h0, 4'h1, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h1, 4'h1, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h1, 4'h1, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 1, 0,  4'h1, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(1, K_A,  0, 1, 0,  4'h0, 4'h2, 2'd2, 0, 2'd2, 0);
      addVec(1, K_D,  1, 1, 0,  4'h2, 4'h1, 2'd2, 0, 2'd2, 0);
      addVec(1, K_A,  0, 1, 0,  4'h0, 4'h2, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(0, 8'h0, 1, 0, 0,  4'h0, 4'h0, 2'd2, 0, 2'd2, 0);
      addVec(1, K_A,  0, 0, 0,  4'h0, 4'h0, 2'd1, 0, 2'd2, 0);

      reset = 1'b1;
      applyStimulus(0, 8'h0, 0, 0, 0);
      applyStimulus(0, 8'h0, 0, 0, 0);
      reset = 1'b0;
      checkOutput("reset", 4'h0, 4'h0, 2'd0, 0, 2'd0, 0);

      // Left from 0 wraps to the last item for both menu sizes
      applyStimulus(1, K_A, 0, 0, 0);
      checkOutput("wrap_left", 4'h0, 4'h0, 2'd3, 0, 2'd0, 0);
      checkField("wrap_left3.cursor", int'(cursor3), 2);
      applyStimulus(1, K_D, 0, 0, 0);
      checkOutput("wrap_right", 4'h0, 4'h0, 2'd0, 0, 2'd0, 0);
      checkField("wrap_right3.cursor", int'(cursor3), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rv, vecs[i].data, vecs[i].tk, vecs[i].dp, vecs[i].rdy);
         checkOutput($sformatf("vec%0d", i), vecs[i].step, vecs[i].held, vecs[i].cur,
                     vecs[i].cv, vecs[i].code, vecs[i].bad);
      end

      // Confirm with ready already high: valid lasts one cycle
      applyStimulus(1, K_J, 0, 0, 1);
      checkOutput("fast_ack_rise", 4'h0, 4'h0, 2'd1, 1, 2'd1, 0);
      applyStimulus(0, 8'h0, 0, 0, 1);
      checkOutput("fast_ack_fall", 4'h0, 4'h0, 2'd1, 0, 2'd1, 0);

      // Phase change during WAIT_ACK waits for the acknowledge, then enters DODGE
      applyStimulus(1, K_J, 0, 0, 0);
      checkOutput("wait_phase_confirm", 4'h0, 4'h0, 2'd1, 1, 2'd1, 0);
      applyStimulus(0, 8'h0, 0, 1, 0);
      checkOutput("wait_phase_hold", 4'h0, 4'h0, 2'd1, 1, 2'd1, 0);
      applyStimulus(1, K_W, 0, 1, 0);
      checkOutput("wait_phase_drop", 4'h0, 4'h0, 2'd1, 1, 2'd1, 0);
      applyStimulus(0, 8'h0, 0, 1, 1);
      checkOutput("wait_phase_ack", 4'h0, 4'h0, 2'd1, 0, 2'd1, 0);
      applyStimulus(1, K_W, 0, 1, 0);
      checkOutput("wait_phase_dodge", 4'h0, 4'h8, 2'd1, 0, 2'd1, 0);

      // Reset mid-hold: no step, even with a coincident or later tick
      reset = 1'b1;
      applyStimulus(0, 8'h0, 1, 1, 0);
      reset = 1'b0;
      checkOutput("reset_hold", 4'h0, 4'h0, 2'd0, 0, 2'd0, 0);
      applyStimulus(0, 8'h0, 1, 1, 0);
      checkOutput("reset_hold_tick", 4'h0, 4'h0, 2'd0, 0, 2'd0, 0);

      // Reset during WAIT_ACK: valid drops and the block is back in MENU
      applyStimulus(0, 8'h0, 0, 0, 0);
      applyStimulus(1, K_D, 0, 0, 0);
      checkOutput("wait_reset_move", 4'h0, 4'h0, 2'd1, 0, 2'd0, 0);
      applyStimulus(1, K_CR, 0, 0, 0);
      checkOutput("wait_reset_confirm", 4'h0, 4'h0, 2'd1, 1, 2'd1, 0);
      reset = 1'b1;
      applyStimulus(0, 8'h0, 0, 0, 0);
      reset = 1'b0;
      checkOutput("wait_reset", 4'h0, 4'h0, 2'd0, 0, 2'd0, 0);
      applyStimulus(1, K_A, 0, 0, 0);
      checkOutput("wait_reset_menu", 4'h0, 4'h0, 2'd3, 0, 2'd0, 0);
      applyStimulus(0, 8'h0, 0, 0, 1);
      checkOutput("wait_reset_idle", 4'h0, 4'h0, 2'd3, 0, 2'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
